// File: rtl/fios_result_collector_if.sv
// Bus bundle between the FIOS multiplier result stream and the collector.
// The master drives the result words and the modulus; the slave returns the reduced result.
interface fios_result_collector_if #(
  parameter int unsigned s          = 8,
  parameter int unsigned WORD_WIDTH = 17
);
  logic                      res_valid_i;
  logic [WORD_WIDTH-1:0]     res_i;
  logic [s*WORD_WIDTH-1:0]   p_i;
  logic [s*WORD_WIDTH-1:0]   result_o;
  logic                      done_o;
  logic                      busy_o;
  logic                      overrun_o;

  modport master (
    output res_valid_i, res_i, p_i,
    input  result_o, done_o, busy_o, overrun_o
  );

  modport slave (
    input  res_valid_i, res_i, p_i,
    output result_o, done_o, busy_o, overrun_o
  );
endinterface

// File: rtl/fios_result_collector.sv
// Collects the LSW-first Montgomery FIOS result words, then performs the final
// conditional subtraction (R >= p ? R - p : R) one word per cycle with borrow.
module fios_result_collector #(
  parameter int unsigned s          = 8,
  parameter int unsigned WORD_WIDTH = 17
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  fios_result_collector_if.slave bus
);

  localparam int unsigned    CW   = (s > 1) ? $clog2(s) : 1;
  localparam logic [CW-1:0]  LAST = CW'(s - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    REDUCE  = 2'd1,
    OUT     = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    borrow_q, borrow_d;
  logic [WORD_WIDTH-1:0]   r_q [s];
  logic [WORD_WIDTH-1:0]   r_d [s];
  logic [WORD_WIDTH-1:0]   d_q [s];
  logic [WORD_WIDTH-1:0]   d_d [s];
  logic [WORD_WIDTH-1:0]   p_w [s];
  logic [s*WORD_WIDTH-1:0] result_q, result_d;
  logic [s*WORD_WIDTH-1:0] r_flat, d_flat;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;
  logic [WORD_WIDTH:0]     diff;

  // Slice the modulus into words and flatten the R/D buffers for the final select
  always_comb begin
    r_flat = '0;
    d_flat = '0;
    for (int unsigned i = 0; i < s; i++) begin
      p_w[i]                               = bus.p_i[i*WORD_WIDTH +: WORD_WIDTH];
      r_flat[i*WORD_WIDTH +: WORD_WIDTH]   = r_q[i];
      d_flat[i*WORD_WIDTH +: WORD_WIDTH]   = d_q[i];
    end
  end

  // One word of the borrow-propagating subtraction R - p
  always_comb begin
    diff = {1'b0, r_q[cnt_q]} - {1'b0, p_w[cnt_q]} - {{WORD_WIDTH{1'b0}}, borrow_q};
  end

  // FSM state register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= COLLECT;
    else         state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (bus.res_valid_i && (cnt_q == LAST)) state_d = REDUCE;
      REDUCE:  if (cnt_q == LAST) state_d = OUT;
      OUT:     state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // FSM outputs and datapath next values
  always_comb begin
    cnt_d     = cnt_q;
    borrow_d  = borrow_q;
    r_d       = r_q;
    d_d       = d_q;
    result_d  = result_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    unique case (state_q)
      COLLECT: begin
        if (bus.res_valid_i) begin
          r_d[cnt_q] = bus.res_i;
          if (cnt_q == LAST) begin
            cnt_d    = '0;
            borrow_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      REDUCE: begin
        d_d[cnt_q] = diff[WORD_WIDTH-1:0];
        borrow_d   = diff[WORD_WIDTH];
        cnt_d      = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        if (bus.res_valid_i) overrun_d = 1'b1;
      end
      OUT: begin
        // A final borrow means R < p, so the unreduced capture is the answer
        result_d = borrow_q ? r_flat : d_flat;
        done_d   = 1'b1;
        cnt_d    = '0;
        if (bus.res_valid_i) overrun_d = 1'b1;
      end
      default: cnt_d = '0;
    endcase
    // Registered busy: derived from the values the flops are about to take
    busy_d = (state_d != COLLECT) || (cnt_d != '0);
  end

  // Datapath and output registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      borrow_q  <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int unsigned i = 0; i < s; i++) begin
        r_q[i] <= '0;
        d_q[i] <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      borrow_q  <= borrow_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      for (int unsigned i = 0; i < s; i++) begin
        r_q[i] <= r_d[i];
        d_q[i] <= d_d[i];
      end
    end
  end

  assign bus.result_o  = result_q;
  assign bus.done_o    = done_q;
  assign bus.busy_o    = busy_q;
  assign bus.overrun_o = overrun_q;

endmodule
